// File: rtl/capture_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | capture_pkg : shared types, constants and count decode for capture   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package capture_pkg;

  localparam int CNT_W    = 18;
  localparam int CNT_UNIT = 4;

  localparam logic [2:0] IDLE_ENC    = 3'd0;
  localparam logic [2:0] ARMED_ENC   = 3'd1;
  localparam logic [2:0] DELAY_ENC   = 3'd2;
  localparam logic [2:0] RD_ADDR_ENC = 3'd3;
  localparam logic [2:0] RD_DATA_ENC = 3'd4;
  localparam logic [2:0] SEND_ENC    = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = IDLE_ENC,
    ST_ARMED   = ARMED_ENC,
    ST_DELAY   = DELAY_ENC,
    ST_RD_ADDR = RD_ADDR_ENC,
    ST_RD_DATA = RD_DATA_ENC,
    ST_SEND    = SEND_ENC
  } capture_state_t;

  // A field of 0xFFFF wraps to 0; callers treat 0 as the full 2^CNT_W count.
  function automatic logic [CNT_W-1:0] decode_cnt(input logic [15:0] fld);
    logic [CNT_W-1:0] ext;
    ext = {{(CNT_W-16){1'b0}}, fld} + CNT_W'(1);
    return ext * CNT_W'(CNT_UNIT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/capture_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | capture_ctrl : ring-buffer sample capture, post-trigger delay and    |
// |                newest-first readback to the transmitter              |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int SMPL_W     = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_in,
  input  logic [31:0]           cmd_i,
  input  logic                  set_cnt_i,
  input  logic                  arm_i,
  input  logic                  run_i,
  input  logic                  stb_i,
  input  logic [SMPL_W-1:0]     smpls_i,
  output logic                  we_o,
  output logic [DEPTH_LOG2-1:0] addr_o,
  output logic [SMPL_W-1:0]     din_o,
  input  logic [SMPL_W-1:0]     dout_i,
  output logic [SMPL_W-1:0]     tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  busy_o
);

  localparam int                    C_DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [CNT_W-1:0]      C_DEPTH_CNT = CNT_W'(C_DEPTH);
  localparam logic [DEPTH_LOG2:0]   C_DEPTH_REM = (DEPTH_LOG2+1)'(C_DEPTH);
  localparam logic [DEPTH_LOG2:0]   C_REM_ONE   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] C_PTR_ONE   = DEPTH_LOG2'(1);
  localparam logic [CNT_W-1:0]      C_CNT_ONE   = CNT_W'(1);

  capture_state_t          state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        dly_ctr_q, dly_ctr_d;
  logic [DEPTH_LOG2:0]     remaining_q, remaining_d;
  logic [15:0]             read_fld_q, read_fld_d;
  logic [15:0]             delay_fld_q, delay_fld_d;
  logic [SMPL_W-1:0]       tx_data_q, tx_data_d;
  logic                    tx_valid_q, tx_valid_d;

  logic [CNT_W-1:0]        w_read_cnt;
  logic [CNT_W-1:0]        w_delay_cnt;
  logic [CNT_W-1:0]        w_dly_next;
  logic [DEPTH_LOG2:0]     w_rem_init;
  logic [DEPTH_LOG2-1:0]   w_wr_ptr_inc;
  logic                    w_capturing;

  assign w_read_cnt   = decode_cnt(read_fld_q);
  assign w_delay_cnt  = decode_cnt(delay_fld_q);
  assign w_dly_next   = dly_ctr_q + C_CNT_ONE;
  assign w_wr_ptr_inc = wr_ptr_q + C_PTR_ONE;
  assign w_capturing  = (state_q == ST_ARMED) || (state_q == ST_DELAY);

  // A zero decode means the wrapped maximum, which always exceeds the depth.
  assign w_rem_init = ((w_read_cnt == '0) || (w_read_cnt > C_DEPTH_CNT))
                      ? C_DEPTH_REM : w_read_cnt[DEPTH_LOG2:0];

  // Memory write path is combinational so the write lands on the strobe edge.
  assign we_o       = stb_i & w_capturing;
  assign din_o      = smpls_i;
  assign addr_o     = w_capturing ? wr_ptr_q : rd_ptr_q;
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign busy_o     = (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    dly_ctr_d   = dly_ctr_q;
    remaining_d = remaining_q;
    read_fld_d  = read_fld_q;
    delay_fld_d = delay_fld_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (set_cnt_i) begin
          read_fld_d  = cmd_i[15:0];
          delay_fld_d = cmd_i[31:16];
        end
        if (arm_i) begin
          state_d = ST_ARMED;
        end
      end

      ST_ARMED: begin
        if (stb_i) begin
          wr_ptr_d = w_wr_ptr_inc;
        end
        if (run_i) begin
          state_d   = ST_DELAY;
          dly_ctr_d = stb_i ? C_CNT_ONE : '0;
        end
      end

      ST_DELAY: begin
        if (stb_i) begin
          wr_ptr_d  = w_wr_ptr_inc;
          dly_ctr_d = w_dly_next;
          if (w_dly_next == w_delay_cnt) begin
            state_d     = ST_RD_ADDR;
            rd_ptr_d    = wr_ptr_q;
            remaining_d = w_rem_init;
          end
        end
      end

      ST_RD_ADDR: begin
        state_d = ST_RD_DATA;
      end

      ST_RD_DATA: begin
        tx_data_d  = dout_i;
        tx_valid_d = 1'b1;
        state_d    = ST_SEND;
      end

      ST_SEND: begin
        if (tx_ready_i) begin
          tx_valid_d = 1'b0;
          if (remaining_q == C_REM_ONE) begin
            state_d = ST_IDLE;
          end else begin
            rd_ptr_d    = rd_ptr_q - C_PTR_ONE;
            remaining_d = remaining_q - C_REM_ONE;
            state_d     = ST_RD_ADDR;
          end
        end
      end

      default: begin
        state_d    = ST_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      dly_ctr_q   <= '0;
      remaining_q <= '0;
      read_fld_q  <= '0;
      delay_fld_q <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      dly_ctr_q   <= dly_ctr_d;
      remaining_q <= remaining_d;
      read_fld_q  <= read_fld_d;
      delay_fld_q <= delay_fld_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_capture_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_capture_ctrl : directed self-checking bench for capture_ctrl      |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module tb_capture_ctrl;

  localparam int DL = 4;
  localparam int SW = 32;

  logic          clk_i = 1'b0;
  logic          rst_in = 1'b0;
  logic [31:0]   cmd_i = '0;
  logic          set_cnt_i = 1'b0;
  logic          arm_i = 1'b0;
  logic          run_i = 1'b0;
  logic          stb_i = 1'b0;
  logic [SW-1:0] smpls_i = '0;
  logic          we_o;
  logic [DL-1:0] addr_o;
  logic [SW-1:0] din_o;
  logic [SW-1:0] dout_i;
  logic [SW-1:0] tx_data_o;
  logic          tx_valid_o;
  logic          tx_ready_i = 1'b0;
  logic          busy_o;

  logic [SW-1:0] mem [16];
  logic [SW-1:0] ram_q = '0;

  int            errors = 0;
  int            checks = 0;
  int            wr_count = 0;
  int            unstable = 0;
  logic [SW-1:0] rx_q [$];
  logic          prev_valid = 1'b0;
  logic          prev_hs = 1'b0;
  logic [SW-1:0] prev_data = '0;

  capture_ctrl #(.DEPTH_LOG2(DL), .SMPL_W(SW)) dut (
    .clk_i      (clk_i),
    .rst_in     (rst_in),
    .cmd_i      (cmd_i),
    .set_cnt_i  (set_cnt_i),
    .arm_i      (arm_i),
    .run_i      (run_i),
    .stb_i      (stb_i),
    .smpls_i    (smpls_i),
    .we_o       (we_o),
    .addr_o     (addr_o),
    .din_o      (din_o),
    .dout_i     (dout_i),
    .tx_data_o  (tx_data_o),
    .tx_valid_o (tx_valid_o),
    .tx_ready_i (tx_ready_i),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Single-port RAM model with one-cycle synchronous read.
  assign dout_i = ram_q;
  always @(posedge clk_i) begin
    if (we_o) mem[addr_o] <= din_o;
    ram_q <= mem[addr_o];
  end

  always @(negedge clk_i) begin
    if (we_o === 1'b1) wr_count++;
    if (tx_valid_o && tx_ready_i) rx_q.push_back(tx_data_o);
    if (rst_in && prev_valid && !prev_hs && (!tx_valid_o || tx_data_o !== prev_data))
      unstable++;
    prev_valid <= tx_valid_o;
    prev_data  <= tx_data_o;
    prev_hs    <= tx_valid_o && tx_ready_i;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Samples are base+1, base+2, ...; run_i rises with sample n_pre+1.
  task automatic do_capture(input string tag, input logic [15:0] rd_f, input logic [15:0] dl_f,
                            input int n_pre, input int stall, input bit poke,
                            input logic [31:0] base, input int exp_n, input int exp_writes);
    int k;
    int wait_c;
    int cyc;
    logic [SW-1:0] got;
    cmd_i = {dl_f, rd_f};
    set_cnt_i = 1'b1;
    step();
    set_cnt_i = 1'b0;
    wr_count = 0;
    unstable = 0;
    rx_q.delete();
    arm_i = 1'b1;
    step();
    arm_i = 1'b0;
    k = 0;
    wait_c = 0;
    cyc = 0;
    do begin
      k++;
      stb_i   = 1'b1;
      smpls_i = base + SW'(k);
      run_i   = (k > n_pre);
      if (poke && k > n_pre) begin
        set_cnt_i = 1'b1;
        arm_i     = 1'b1;
        cmd_i     = '1;
      end
      if (tx_valid_o) begin
        if (wait_c < stall) begin
          tx_ready_i = 1'b0;
          wait_c++;
        end else begin
          tx_ready_i = 1'b1;
          wait_c = 0;
        end
      end else begin
        tx_ready_i = 1'b1;
      end
      step();
      cyc++;
    end while (busy_o && cyc < 600);
    stb_i = 1'b0;
    run_i = 1'b0;
    set_cnt_i = 1'b0;
    arm_i = 1'b0;
    tx_ready_i = 1'b0;
    step();
    check_eq({tag, " idle_at_end"}, {63'd0, busy_o}, 64'd0);
    check_eq({tag, " word_count"}, rx_q.size(), exp_n);
    check_eq({tag, " write_count"}, wr_count, exp_writes);
    check_eq({tag, " unstable"}, unstable, 0);
    for (int i = 0; i < exp_n; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 32'hDEAD_BEEF;
      check_eq($sformatf("%s word%0d", tag, i), got, base + SW'(exp_writes) - SW'(i));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    int k;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset values, with a strobe present to show nothing is written in reset.
    stb_i   = 1'b1;
    smpls_i = 32'h1234_5678;
    #12;
    check_eq("rst we", {63'd0, we_o}, 64'd0);
    check_eq("rst addr", {60'd0, addr_o}, 64'd0);
    check_eq("rst din", {32'd0, din_o}, 64'h1234_5678);
    check_eq("rst tx_valid", {63'd0, tx_valid_o}, 64'd0);
    check_eq("rst tx_data", {32'd0, tx_data_o}, 64'd0);
    check_eq("rst busy", {63'd0, busy_o}, 64'd0);
    stb_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_in = 1'b1;
    step();

    do_capture("basic", 16'd0, 16'd0, 10, 0, 1'b0, 32'd0, 4, 14);
    do_capture("wrap", 16'd3, 16'd0, 20, 0, 1'b0, 32'd100, 16, 24);
    do_capture("clip", 16'd7, 16'd0, 20, 0, 1'b0, 32'd200, 16, 24);
    do_capture("bp", 16'd0, 16'd1, 3, 5, 1'b0, 32'd300, 4, 11);
    do_capture("ignore", 16'd1, 16'd0, 5, 2, 1'b1, 32'd700, 8, 9);

    // Reset while a word is waiting in SEND.
    cmd_i = '0;
    set_cnt_i = 1'b1;
    step();
    set_cnt_i = 1'b0;
    arm_i = 1'b1;
    step();
    arm_i = 1'b0;
    tx_ready_i = 1'b0;
    k = 0;
    while (!tx_valid_o && k < 50) begin
      k++;
      stb_i   = 1'b1;
      smpls_i = 32'd500 + SW'(k);
      run_i   = (k > 2);
      step();
    end
    stb_i = 1'b0;
    run_i = 1'b0;
    check_eq("pre_rst valid", {63'd0, tx_valid_o}, 64'd1);
    check_eq("pre_rst data", {32'd0, tx_data_o}, 64'd506);
    step();
    step();
    check_eq("pre_rst held", {32'd0, tx_data_o}, 64'd506);
    #2;
    rst_in = 1'b0;
    #1;
    check_eq("mid_rst tx_valid", {63'd0, tx_valid_o}, 64'd0);
    check_eq("mid_rst busy", {63'd0, busy_o}, 64'd0);
    check_eq("mid_rst tx_data", {32'd0, tx_data_o}, 64'd0);
    check_eq("mid_rst addr", {60'd0, addr_o}, 64'd0);
    step();
    rst_in = 1'b1;
    step();

    do_capture("post_rst", 16'd0, 16'd0, 2, 0, 1'b0, 32'd600, 4, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/capture_ctrl.md
# capture_ctrl

Sample-capture controller for the logic analyzer core. It sits directly downstream of the trigger stage and consumes its `run` output together with the same sample strobe and sample word. While armed it writes every strobed sample into an external single-port ring-buffer RAM. Once the trigger fires, it records a programmed number of post-trigger samples, then reads back a programmed number of samples newest-first and hands them one word at a time to the transmitter.

## Interface
Parameters:
- `DEPTH_LOG2`, default 10: ring-buffer depth is 2^DEPTH_LOG2 words.
- `SMPL_W`, default 32: sample width.

Ports:
- `clk_i` in 1: single clock, all logic is rising-edge.
- `rst_in` in 1: reset, asynchronous, active-low.
- `cmd_i` in 32: command payload.
- `set_cnt_i` in 1: one-cycle strobe that latches `cmd_i[15:0]` as the read field and `cmd_i[31:16]` as the delay field.
- `arm_i` in 1: one-cycle arm strobe.
- `run_i` in 1: trigger-fired level from the trigger stage; it stays high until re-armed.
- `stb_i` in 1: sample-valid strobe.
- `smpls_i` in SMPL_W: sample word.
- `we_o` out 1: RAM write enable.
- `addr_o` out DEPTH_LOG2: RAM address.
- `din_o` out SMPL_W: RAM write data.
- `dout_i` in SMPL_W: RAM read data, one-cycle synchronous read latency.
- `tx_data_o` out SMPL_W: word to the transmitter.
- `tx_valid_o` out 1: `tx_data_o` is valid.
- `tx_ready_i` in 1: transmitter accepts the word.
- `busy_o` out 1: high when the state is not IDLE.

## Operation
- Count decode:
  - read_cnt = (read field + 1) * 4.
  - delay_cnt = (delay field + 1) * 4.
  - Both are 18-bit unsigned values, range 4..262144.
  - Both fields reset to 0, which gives 4/4.
  - read_cnt is clipped to 2^DEPTH_LOG2 when used.
- `set_cnt_i` is honoured only in IDLE and ignored in all other states.
- FSM states: IDLE, ARMED, DELAY, RD_ADDR, RD_DATA, SEND.
- IDLE:
  - `arm_i` moves to ARMED.
  - wr_ptr is not cleared; the ring buffer keeps writing from the previous position.
- ARMED:
  - Each `stb_i` writes `smpls_i` at wr_ptr, then wr_ptr increments modulo the depth.
  - `run_i`=1 moves to DELAY with dly_ctr=0.
  - If `stb_i` is also high in that cycle, the sample is written and counted, so dly_ctr becomes 1 on entry.
- DELAY:
  - Each `stb_i` writes the sample and increments dly_ctr.
  - When a write makes dly_ctr == delay_cnt, the next state is RD_ADDR.
  - At that point rd_ptr = (wr_ptr after increment) − 1 (the last written word) and remaining = min(read_cnt, depth).
- RD_ADDR: drives addr_o=rd_ptr with we_o=0, then goes to RD_DATA.
- RD_DATA: latches `dout_i` into `tx_data_o`, then goes to SEND.
- SEND:
  - `tx_valid_o`=1, and `tx_data_o` is held stable until `tx_ready_i`.
  - On handshake with remaining==1: go to IDLE.
  - On handshake otherwise: rd_ptr decrements modulo the depth, remaining decrements, and the state goes to RD_ADDR.
- Pointer arithmetic:
  - rd_ptr and wr_ptr are DEPTH_LOG2 bits and wrap naturally (0 − 1 → depth−1).
  - If fewer than read_cnt samples were ever written, stale or unwritten RAM contents are sent. No fill tracking.
- `arm_i` outside IDLE is ignored. `stb_i` in IDLE and in the read states is ignored (nothing is written).
- Reset mid-operation returns immediately to IDLE, discards the transfer, and drops `tx_valid_o` at once.

## Timing
- The memory write path is combinational:
  - `we_o` = `stb_i` & (ARMED|DELAY).
  - `din_o` = `smpls_i`.
  - `addr_o` = wr_ptr in ARMED/DELAY, rd_ptr otherwise.
  - The write lands on the same edge as the strobe.
- Read data appears on `dout_i` one cycle after `addr_o`, i.e. in RD_DATA.
- Per word the minimum is 3 cycles (RD_ADDR, RD_DATA, SEND with ready already high).
- After the last delay write, RD_ADDR is entered on the next edge, so the first word is valid 2 cycles later.
- Reset values:
  - `we_o`=0, `addr_o`=0, `din_o` follows `smpls_i`.
  - `tx_data_o`=0, `tx_valid_o`=0, `busy_o`=0.
  - wr_ptr=0, rd_ptr=0, both count fields=0, state=IDLE.
- `tx_valid_o` and `tx_data_o` are registered. `tx_valid_o` never drops without a handshake, except on reset.

## Structure
- Shared package `capture_pkg`:
  - state enum `capture_state_t`.
  - localparams `CNT_W`=18 and `CNT_UNIT`=4.
  - function `decode_cnt(logic [15:0]) → logic [CNT_W-1:0]`.
- The RAM is not inside this block. It is instantiated alongside it as `capture_ram` (single-port, synchronous read, depth 2^DEPTH_LOG2).
- No sub-module is needed inside `capture_ctrl`.

## Test plan
All scenarios use DEPTH_LOG2=4 and a RAM model.
- Reset defaults: assert `rst_in`=0 mid-SEND → `tx_valid_o` drops asynchronously, state is IDLE, `busy_o`=0; after release, `arm_i` works again.
- Basic capture with samples = incrementing counter 1,2,3…, read field=0 and delay field=0:
  - Arm, strobe 10 samples, raise `run_i` on the sample with value 11, keep strobing.
  - Expect exactly 4 delay samples (11..14) written, then words 14,13,12,11 sent newest-first, then IDLE.
- Wrap-around:
  - Strobe 20 samples before the trigger, delay field=0, read field=3 (16, equal to depth).
  - Expect 16 words, newest-first, with rd_ptr crossing 0→15 and contents consistent with the last 16 writes.
- Clipping: read field=7 (32 > 16) → exactly 16 words sent.
- Backpressure: hold `tx_ready_i`=0 for 5 cycles on each word → `tx_data_o` stays stable, no word is lost or duplicated, order is preserved.
- Ignored inputs:
  - `set_cnt_i` and `arm_i` pulsed during DELAY and SEND → no effect.
  - `stb_i` during the read states → `we_o` stays 0.
